mult_arbiter: RTL and testbench

//  Shares one mult_32 multiplier between N_REQ independent requesters, e.g. the J1 peripheral path and a DMA engine.

---
 rtl/mult_arbiter_pkg.sv | 16 +
 rtl/mult_arbiter_rr_arbiter.sv | 30 +++
 rtl/mult_arbiter.sv | 120 ++++++++++++
 tb/tb_mult_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int OP_W            = 16;
    localparam int PROD_W          = 32;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] slot;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[slot]) begin
                found     = 1'b1;
                gnt[slot] = 1'b1;
                gnt_idx   = slot;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external mult_32 between N_REQ requesters: round-robin grant,
// operand latch, init pulse, bounded wait for done, one-cycle ack.
//
//  state     | meaning
//  ST_IDLE   | no job; grant sampled here, winner's operands latched
//  ST_LAUNCH | m_init high for this single cycle, timeout counter loaded
//  ST_WAIT   | waiting for m_done (ignored in first cycle) or timeout
//  ST_RESP   | ack to owner, rr pointer moves past owner
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [OP_W*N_REQ-1:0] op_a,
    input  logic [OP_W*N_REQ-1:0] op_b,
    output logic [N_REQ-1:0]      ack,
    output logic [PROD_W-1:0]     result,
    output logic                  err,
    output logic                  busy,
    output logic [OP_W-1:0]       m_A,
    output logic [OP_W-1:0]       m_B,
    output logic                  m_init,
    input  logic [PROD_W-1:0]     m_pp,
    input  logic                  m_done
);

    localparam int               IDX_W    = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx, owner, ptr;
    logic [OP_W-1:0]  op_a_sel, op_b_sel;
    logic [CNT_W-1:0] tmo_cnt;
    logic             first_wait, done_hit, tmo_hit;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        op_a_sel = '0;
        op_b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                op_a_sel = op_a[i*OP_W +: OP_W];
                op_b_sel = op_b[i*OP_W +: OP_W];
            end
        end
    end

    // Down-counter: equals TIMEOUT in the first WAIT cycle, reaches 1 in the TIMEOUT-th.
    assign first_wait = (tmo_cnt == TMO_LOAD);
    assign done_hit   = (state == ST_WAIT) && m_done && !first_wait;
    assign tmo_hit    = (state == ST_WAIT) && (tmo_cnt <= CNT_W'(1));

    always_comb begin
        state_nxt = state;
        ack       = '0;
        case (state)
            ST_IDLE:   if (|gnt) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_WAIT;
            ST_WAIT:   if (done_hit || tmo_hit) state_nxt = ST_RESP;
            ST_RESP: begin
                ack[owner] = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign m_init = (state == ST_LAUNCH);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner   <= '0;
            ptr     <= '0;
            tmo_cnt <= '0;
            m_A     <= '0;
            m_B     <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner <= gnt_idx;
                        m_A   <= op_a_sel;
                        m_B   <= op_b_sel;
                    end
                end
                ST_LAUNCH: tmo_cnt <= TMO_LOAD;
                ST_WAIT: begin
                    if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - CNT_W'(1);
                    // done has priority over a timeout landing in the same cycle
                    if (done_hit) begin
                        result <= m_pp;
                        err    <= 1'b0;
                    end else if (tmo_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                ST_RESP: ptr <= (int'(owner) == N_REQ - 1) ? '0 : owner + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: stub mult_32 with programmable latency, a transaction-level
// reference model checked every cycle, directed scenarios and randomized requesters.
module tb_mult_arbiter;

    localparam int N   = 2;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [16*N-1:0] op_a = '0;
    logic [16*N-1:0] op_b = '0;
    logic [N-1:0]  ack;
    logic [31:0]   result;
    logic          err, busy, m_init;
    logic [15:0]   m_A, m_B;
    logic [31:0]   m_pp = '0;
    logic          m_done = 1'b0;

    mult_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op_a   (op_a),
        .op_b   (op_b),
        .ack    (ack),
        .result (result),
        .err    (err),
        .busy   (busy),
        .m_A    (m_A),
        .m_B    (m_B),
        .m_init (m_init),
        .m_pp   (m_pp),
        .m_done (m_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stub mult_32: done stays at its old level during the cycle after init,
    // then rises stub_lat cycles after the init cycle; stub_lat == 0 never finishes.
    int          stub_lat = 3;
    int          s_left   = 0;
    bit          s_run    = 1'b0;
    logic [31:0] s_prod   = '0;

    always @(posedge clk) begin
        if (m_init) begin
            s_left <= (stub_lat == 0) ? 0 : stub_lat - 1;
            s_prod <= 32'(m_A) * 32'(m_B);
            s_run  <= 1'b1;
        end else if (s_run) begin
            if (s_left == 1) begin
                m_done <= 1'b1;
                m_pp   <= s_prod;
                s_run  <= 1'b0;
            end else begin
                m_done <= 1'b0;
                if (s_left != 0) s_left <= s_left - 1;
            end
        end
    end

    // Transaction-level model: one job at a time, response time from stub latency vs TIMEOUT.
    bit          mf_free = 1'b1;
    int          m_ptr = 0, m_idx = 0, m_init_cyc = -1, m_resp_cyc = -1, pick;
    logic [15:0] m_opa = '0, m_opb = '0;
    logic [31:0] m_res = '0;
    logic        m_err = 1'b0;
    logic [N-1:0] e_ack, last_ack = '0;
    logic        e_busy, e_init;
    int          init_count = 0, init_cyc = 0, model_acks = 0;

    initial forever begin
        @(negedge clk);
        last_ack = ack;
        if (m_init) begin
            init_count++;
            init_cyc = cyc;
        end
        if (!rst) begin
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_m_init", 32'(m_init), 32'd0);
            check("rst_result", result, 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_m_A", 32'(m_A), 32'd0);
            check("rst_m_B", 32'(m_B), 32'd0);
            mf_free = 1'b1;
            m_ptr   = 0;
        end else begin
            e_ack  = '0;
            e_busy = !mf_free;
            e_init = !mf_free && (cyc == m_init_cyc);
            if (!mf_free && cyc == m_resp_cyc) e_ack[m_idx] = 1'b1;
            check("ack", 32'(ack), 32'(e_ack));
            check("busy", 32'(busy), 32'(e_busy));
            check("m_init", 32'(m_init), 32'(e_init));
            if (e_init) begin
                check("m_A", 32'(m_A), 32'(m_opa));
                check("m_B", 32'(m_B), 32'(m_opb));
            end
            if (e_ack != '0) begin
                check("result", result, m_res);
                check("err", 32'(err), 32'(m_err));
                model_acks++;
            end
            if (mf_free) begin
                pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                if (pick >= 0) begin
                    mf_free    = 1'b0;
                    m_idx      = pick;
                    m_opa      = op_a[16*pick +: 16];
                    m_opb      = op_b[16*pick +: 16];
                    m_init_cyc = cyc + 1;
                    m_resp_cyc = -1;
                end
            end else if (cyc == m_init_cyc) begin
                if (stub_lat >= 2 && stub_lat <= TMO) begin
                    m_resp_cyc = cyc + stub_lat + 1;
                    m_res      = 32'(m_opa) * 32'(m_opb);
                    m_err      = 1'b0;
                end else begin
                    m_resp_cyc = cyc + TMO + 1;
                    m_res      = '0;
                    m_err      = 1'b1;
                end
            end else if (cyc == m_resp_cyc) begin
                mf_free = 1'b1;
                m_ptr   = (m_idx + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int idx, output logic [31:0] r, output logic e, output int at);
        bit ok;
        ok = 1'b0; idx = -1; r = '0; e = 1'b0; at = 0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (ack != '0) begin
                ok  = 1'b1;
                idx = ack[1] ? 1 : 0;
                r   = result;
                e   = err;
                at  = cyc;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ack_timeout: got no ack, expected one within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int          idx, at;
        logic [31:0] r;
        logic        e;

        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;

        // single requester, 3*5
        init_count = 0;
        step();
        op_a[15:0] = 16'd3; op_b[15:0] = 16'd5; req = 2'b01;
        wait_ack(idx, r, e, at);
        check("t1_idx", 32'(idx), 32'd0);
        check("t1_result", r, 32'd15);
        check("t1_err", 32'(e), 32'd0);
        step();
        req = '0;
        @(negedge clk);
        check("t1_busy_after_ack", 32'(busy), 32'd0);
        check("t1_init_pulses", 32'(init_count), 32'd1);

        // both held after reset: grants alternate starting at 0
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        op_a = {16'd100, 16'd7}; op_b = {16'd300, 16'd9}; req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_ack(idx, r, e, at);
            check("t2_order", 32'(idx), 32'(t % 2));
            check("t2_result", r, (t % 2 == 0) ? 32'd63 : 32'd30000);
        end
        step(); req = '0;

        // operand change one cycle after grant must not leak into the product
        step();
        op_a[15:0] = 16'h1234; op_b[15:0] = 16'h0002; req = 2'b01;
        step();
        op_a[15:0] = 16'h0000;
        wait_ack(idx, r, e, at);
        check("t3_idx", 32'(idx), 32'd0);
        check("t3_hold", r, 32'h0000_2468);
        step(); req = '0;

        // mult never finishes: timeout after TIMEOUT WAIT cycles
        step();
        stub_lat = 0; op_a[31:16] = 16'h0042; op_b[31:16] = 16'h0007; req = 2'b10;
        wait_ack(idx, r, e, at);
        check("t4_idx", 32'(idx), 32'd1);
        check("t4_err", 32'(e), 32'd1);
        check("t4_result", r, 32'd0);
        check("t4_wait_cycles", 32'(at - (init_cyc + 1)), 32'd10);
        step(); req = '0; stub_lat = 3;

        // full-scale operands
        step();
        op_a[15:0] = 16'h0000; op_b[15:0] = 16'hFFFF; req = 2'b01;
        wait_ack(idx, r, e, at);
        check("t5_zero", r, 32'd0);
        check("t5_zero_err", 32'(e), 32'd0);
        step(); req = '0;
        step();
        op_a[31:16] = 16'hFFFF; op_b[31:16] = 16'hFFFF; req = 2'b10;
        wait_ack(idx, r, e, at);
        check("t5_full", r, 32'hFFFE_0001);
        step(); req = '0;

        // reset while in WAIT; the abandoned run later leaves a stale done high
        step();
        stub_lat = 8; op_a[15:0] = 16'h00AA; op_b[15:0] = 16'h0011; req = 2'b01;
        step(); step(); step();
        rst = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ack", 32'(ack), 32'd0);
        check("t6_result", result, 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_m_A", 32'(m_A), 32'd0);
        check("t6_m_init", 32'(m_init), 32'd0);
        req = '0;
        step(); step(); rst = 1'b1;
        repeat (10) step();
        check("t6_stub_stale_done", 32'(m_done), 32'd1);
        stub_lat = 4; op_a[15:0] = 16'h0101; op_b[15:0] = 16'h0003; req = 2'b01;
        wait_ack(idx, r, e, at);
        check("t6_after_rst", r, 32'h0000_0303);
        check("t6_after_rst_err", 32'(e), 32'd0);
        step(); req = '0;

        // randomized requesters, latencies and operand churn
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 7) == 0)
                stub_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 14));
            for (int i = 0; i < N; i++) begin
                if (req[i] && last_ack[i]) req[i] = 1'b0;
                else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    op_a[16*i +: 16] = rand_op();
                    op_b[16*i +: 16] = rand_op();
                end
                if (req[i] && $urandom_range(0, 3) == 0) op_a[16*i +: 16] = rand_op();
            end
        end

        step(); req = '0; stub_lat = 3;
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd0);
        check("random_acks_seen", 32'(model_acks > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
